axil_slave_if: RTL and testbench

AXI4-Lite slave front end for the peripheral register bank. Terminates the five AXI4-Lite channels from the interconnect and converts each accepted transaction into the bank's single-cycle `write_en` / `read_en` strobes. Captures bank read data and returns it on the R channel. Read and write paths are independent FSMs and may run concurrently; each handles one outstanding transaction.

---
 rtl/axil_slave_if.sv | 233 +++++++++++++++++++++++
 tb/tb_axil_slave_if.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave_if.sv
// axil_slave_if
// AXI4-Lite slave front end for the peripheral register bank. Terminates the
// five AXI4-Lite channels and turns each accepted transaction into a
// single-cycle write_en / read_en strobe toward the bank. Read and write
// paths are independent FSMs, each with one outstanding transaction.
//
// Optional feature: define AXIL_ERR_RESP_EN to answer misaligned or
// out-of-range addresses (above C_MAX_ADDR) with SLVERR without touching
// the bank. Without it every address is forwarded and answered OKAY.
module axil_slave_if #(
  parameter int                      C_DATA_WIDTH = 32,
  parameter int                      C_ADDR_WIDTH = 32,
  parameter logic [C_ADDR_WIDTH-1:0] C_MAX_ADDR   = 'h10
) (
  input  logic                      clk,
  input  logic                      reset,
  // write address
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  // write data
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  // write response
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  // read address
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                s_axi_arprot,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  // read data
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  // register bank side
  output logic                      write_en,
  output logic [C_ADDR_WIDTH-1:0]   write_addr,
  output logic [C_DATA_WIDTH-1:0]   write_data,
  output logic [C_DATA_WIDTH/8-1:0] write_strb,
  output logic                      read_en,
  output logic [C_ADDR_WIDTH-1:0]   read_addr,
  input  logic [C_DATA_WIDTH-1:0]   read_data,
  input  logic                      read_valid
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXIL_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_WAIT, R_RESP} r_state_e;

  // Protection bits carry no meaning for this bank.
  logic unused_prot;
  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  // Misaligned or beyond the last register; constant false when disabled.
  function automatic logic addr_err(input logic [C_ADDR_WIDTH-1:0] a);
    return ERR_EN && ((a[1:0] != 2'b00) || (a > C_MAX_ADDR));
  endfunction

  // ---------------------------------------------------------------- write
  w_state_e                  w_state_q, w_state_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q,  w_done_d;
  logic [C_ADDR_WIDTH-1:0]   awaddr_q,  awaddr_d;
  logic [C_DATA_WIDTH-1:0]   wdata_q,   wdata_d;
  logic [C_DATA_WIDTH/8-1:0] wstrb_q,   wstrb_d;
  logic [1:0]                bresp_q,   bresp_d;
  logic                      aw_rdy, w_rdy, aw_hs, w_hs;

  // Write FSM: collect AW and W in any order, pulse the bank, then answer B.
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    write_en  = 1'b0;
    s_axi_bvalid = 1'b0;
    // Ready only in idle, only for a channel not yet captured, never in reset.
    aw_rdy = !reset && (w_state_q == W_IDLE) && !aw_done_q;
    w_rdy  = !reset && (w_state_q == W_IDLE) && !w_done_q;
    aw_hs  = aw_rdy && s_axi_awvalid;
    w_hs   = w_rdy  && s_axi_wvalid;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          awaddr_d  = s_axi_awaddr;
        end
        if (w_hs) begin
          w_done_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
        end
        if (aw_done_d && w_done_d) begin
          if (addr_err(awaddr_d)) begin
            bresp_d   = RESP_SLVERR;
            w_state_d = W_RESP;
          end else begin
            bresp_d   = RESP_OKAY;
            w_state_d = W_EXEC;
          end
        end
      end
      W_EXEC: begin
        write_en  = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write state and holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  assign s_axi_awready = aw_rdy;
  assign s_axi_wready  = w_rdy;
  assign s_axi_bresp   = bresp_q;
  assign write_addr    = awaddr_q;
  assign write_data    = wdata_q;
  assign write_strb    = wstrb_q;

  // ----------------------------------------------------------------- read
  r_state_e                r_state_q, r_state_d;
  logic [C_ADDR_WIDTH-1:0] araddr_q,  araddr_d;
  logic [C_DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]              rresp_q,   rresp_d;
  logic                    ar_rdy;

  // Read FSM: accept AR, pulse the bank, wait for its registered data, answer R.
  always_comb begin
    r_state_d    = r_state_q;
    araddr_d     = araddr_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    read_en      = 1'b0;
    s_axi_rvalid = 1'b0;
    ar_rdy       = !reset && (r_state_q == R_IDLE);
    case (r_state_q)
      R_IDLE: begin
        if (ar_rdy && s_axi_arvalid) begin
          araddr_d = s_axi_araddr;
          if (addr_err(s_axi_araddr)) begin
            // Bank is bypassed; answer straight away with zero data.
            rdata_d   = '0;
            rresp_d   = RESP_SLVERR;
            r_state_d = R_RESP;
          end else begin
            r_state_d = R_EXEC;
          end
        end
      end
      R_EXEC: begin
        read_en   = 1'b1;
        r_state_d = R_WAIT;
      end
      R_WAIT: begin
        if (read_valid) begin
          rdata_d   = read_data;
          rresp_d   = RESP_OKAY;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read state and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi_arready = ar_rdy;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign read_addr     = araddr_q;

endmodule

// File: tb/tb_axil_slave_if.sv
// Bench for axil_slave_if: directed vector table, multi-cycle corner cases
// (B stall, concurrent R/W, reset in the read wait), then random traffic
// scored against a word-array model of the register bank.
module tb_axil_slave_if;
`ifdef AXIL_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [1:0] OK = 2'b00, SLV = 2'b10;

  logic        clk = 1'b0, reset;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [2:0]  s_axi_awprot, s_axi_arprot;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic        write_en, read_en;
  logic [31:0] write_addr, write_data, read_addr;
  logic [3:0]  write_strb;
  logic [31:0] read_data = '0;
  logic        read_valid = 1'b0;

  axil_slave_if dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .write_strb(write_strb), .read_en(read_en), .read_addr(read_addr),
    .read_data(read_data), .read_valid(read_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register bank: byte-strobed writes, read data returned one cycle later.
  logic [31:0] mem [64] = '{default: 32'h0};
  always @(posedge clk) begin
    read_valid <= reset ? 1'b0 : read_en;
    if (read_en) read_data <= mem[read_addr[7:2]];
    if (write_en)
      for (int b = 0; b < 4; b++)
        if (write_strb[b]) mem[write_addr[7:2]][8*b +: 8] <= write_data[8*b +: 8];
  end

  // Strobe monitor.
  int we_cnt = 0, re_cnt = 0, we_cyc = 0, re_cyc = 0;
  logic [31:0] we_addr, we_data, re_addr;
  logic [3:0]  we_strb;
  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      we_cnt++; we_cyc = cyc; we_addr = write_addr; we_data = write_data; we_strb = write_strb;
    end
    if (read_en === 1'b1) begin
      re_cnt++; re_cyc = cyc; re_addr = read_addr;
    end
  end

  // Reference model: the bank as a plain word array.
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  function automatic bit model_err(input logic [31:0] a);
    return ERR_EN && ((a % 4 != 0) || (a > 32'h10));
  endfunction
  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[(a / 4) % 64][8*b +: 8] = d[8*b +: 8];
  endtask

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] exp_resp);
    bit aw_ok = 0, w_ok = 0, err;
    int aw_c = 0, w_c = 0, hs_c, bv_c = -1, we0;
    err = (exp_resp != OK);
    we0 = we_cnt;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb; s_axi_bready = 1'b0;
    for (int t = 0; t < 40 && !(aw_ok && w_ok); t++) begin
      s_axi_awvalid = !aw_ok && (t >= aw_dly);
      s_axi_wvalid  = !w_ok  && (t >= w_dly);
      @(negedge clk);
      if (aw_ok) chk("awready_low_after_aw", s_axi_awready, 1'b0);
      if (w_ok)  chk("wready_low_after_w",   s_axi_wready,  1'b0);
      if (s_axi_awvalid && s_axi_awready) begin aw_ok = 1; aw_c = cyc; end
      if (s_axi_wvalid  && s_axi_wready)  begin w_ok  = 1; w_c  = cyc; end
      @(posedge clk); #1;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("aw_w_handshake", aw_ok && w_ok, 1'b1);
    if (!(aw_ok && w_ok)) return;
    hs_c = (aw_c > w_c) ? aw_c : w_c;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (s_axi_bvalid) begin bv_c = cyc; break; end
      @(posedge clk); #1;
    end
    chk("bvalid_seen", bv_c >= 0, 1'b1);
    if (bv_c < 0) return;
    chk("bvalid_latency", bv_c - hs_c, err ? 1 : 2);
    for (int k = 0; k < b_dly; k++) begin
      chk("bvalid_held", s_axi_bvalid, 1'b1);
      chk("awready_low_in_b", s_axi_awready, 1'b0);
      chk("wready_low_in_b", s_axi_wready, 1'b0);
      @(posedge clk); #1; @(negedge clk);
    end
    chk("bresp", s_axi_bresp, exp_resp);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    @(negedge clk);
    chk("bvalid_dropped", s_axi_bvalid, 1'b0);
    chk("awready_after_b", s_axi_awready, 1'b1);
    chk("wready_after_b", s_axi_wready, 1'b1);
    chk("write_en_count", we_cnt - we0, err ? 0 : 1);
    if (!err) begin
      chk("write_en_cycle", we_cyc - hs_c, 1);
      chk("write_addr", we_addr, addr);
      chk("write_data", we_data, data);
      chk("write_strb", we_strb, strb);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    bit ok = 0, err;
    int hs_c = 0, rv_c = -1, re0;
    err = (exp_resp != OK);
    re0 = re_cnt;
    s_axi_araddr = addr; s_axi_rready = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      s_axi_arvalid = (t >= ar_dly);
      @(negedge clk);
      if (s_axi_arvalid && s_axi_arready) begin ok = 1; hs_c = cyc; end
      @(posedge clk); #1;
    end
    s_axi_arvalid = 1'b0;
    chk("ar_handshake", ok, 1'b1);
    if (!ok) return;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (s_axi_rvalid) begin rv_c = cyc; break; end
      @(posedge clk); #1;
    end
    chk("rvalid_seen", rv_c >= 0, 1'b1);
    if (rv_c < 0) return;
    chk("rvalid_latency", rv_c - hs_c, err ? 1 : 3);
    for (int k = 0; k < r_dly; k++) begin
      chk("rvalid_held", s_axi_rvalid, 1'b1);
      chk("rdata_stable", s_axi_rdata, exp_data);
      chk("rresp_stable", s_axi_rresp, exp_resp);
      @(posedge clk); #1; @(negedge clk);
    end
    chk("rdata", s_axi_rdata, exp_data);
    chk("rresp", s_axi_rresp, exp_resp);
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    @(negedge clk);
    chk("rvalid_dropped", s_axi_rvalid, 1'b0);
    chk("arready_after_r", s_axi_arready, 1'b1);
    chk("read_en_count", re_cnt - re0, err ? 0 : 1);
    if (!err) begin
      chk("read_en_cycle", re_cyc - hs_c, 1);
      chk("read_addr", re_addr, addr);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          d_addr;
    int          d_data;
    int          d_resp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [12];
    logic [31:0] pool [7];
    logic [31:0] a, d, e;
    logic [3:0]  s;
    logic [1:0]  rs;
    int          we_snap, re_snap;

    vecs[0]  = '{1'b1, 32'h00, 32'h0000_00A5, 4'h1, 0, 0, 0, 32'h0, OK};
    vecs[1]  = '{1'b1, 32'h04, 32'h0000_1234, 4'h3, 3, 0, 0, 32'h0, OK};
    vecs[2]  = '{1'b0, 32'h04, 32'h0, 4'h0, 0, 0, 0, 32'h0000_1234, OK};
    vecs[3]  = '{1'b0, 32'h00, 32'h0, 4'h0, 1, 0, 1, 32'h0000_00A5, OK};
    vecs[4]  = '{1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, 1, 2, 1, 32'h0, OK};
    vecs[5]  = '{1'b1, 32'h08, 32'h1122_3344, 4'h4, 2, 0, 0, 32'h0, OK};
    vecs[6]  = '{1'b0, 32'h08, 32'h0, 4'h0, 2, 0, 2, 32'hDE22_BEEF, OK};
    vecs[7]  = '{1'b1, 32'h14, 32'hCAFE_0000, 4'hF, 0, 0, 0, 32'h0, ERR_EN ? SLV : OK};
    vecs[8]  = '{1'b0, 32'h14, 32'h0, 4'h0, 0, 0, 0, ERR_EN ? 32'h0 : 32'hCAFE_0000, ERR_EN ? SLV : OK};
    vecs[9]  = '{1'b0, 32'h02, 32'h0, 4'h0, 0, 0, 0, ERR_EN ? 32'h0 : 32'h0000_00A5, ERR_EN ? SLV : OK};
    vecs[10] = '{1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, 0, 1, 0, 32'h0, OK};
    vecs[11] = '{1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 1, 32'h0BAD_F00D, OK};
    pool = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h02};

    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0; s_axi_bready = 0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 0; s_axi_rready = 0;

    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_awready", s_axi_awready, 1'b0);
    chk("rst_wready", s_axi_wready, 1'b0);
    chk("rst_arready", s_axi_arready, 1'b0);
    chk("rst_bvalid", s_axi_bvalid, 1'b0);
    chk("rst_rvalid", s_axi_rvalid, 1'b0);
    chk("rst_write_en", write_en, 1'b0);
    chk("rst_read_en", read_en, 1'b0);
    chk("rst_bresp", s_axi_bresp, 2'b00);
    chk("rst_rresp", s_axi_rresp, 2'b00);
    chk("rst_rdata", s_axi_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", s_axi_awready, 1'b1);
    chk("post_rst_wready", s_axi_wready, 1'b1);
    chk("post_rst_arready", s_axi_arready, 1'b1);
    chk("post_rst_write_addr", write_addr, 32'h0);
    chk("post_rst_write_data", write_data, 32'h0);
    chk("post_rst_write_strb", write_strb, 4'h0);
    chk("post_rst_read_addr", read_addr, 32'h0);
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb,
                 vecs[i].d_addr, vecs[i].d_data, vecs[i].d_resp, vecs[i].exp_resp);
        if (!model_err(vecs[i].addr)) ref_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      end else begin
        do_read(vecs[i].addr, vecs[i].d_addr, vecs[i].d_resp, vecs[i].exp_rdata, vecs[i].exp_resp);
      end
    end

    // B held off for 5 cycles.
    do_write(32'h0C, 32'h5A5A_0F0F, 4'hF, 0, 0, 5, OK);
    ref_write(32'h0C, 32'h5A5A_0F0F, 4'hF);

    // Read stalled on R while a write to another register runs alongside.
    e = ref_mem[2];
    fork
      do_read(32'h08, 0, 4, e, OK);
      do_write(32'h00, 32'h0000_0077, 4'h1, 1, 1, 0, OK);
    join
    ref_write(32'h00, 32'h0000_0077, 4'h1);
    do_read(32'h00, 0, 0, ref_mem[0], OK);

    // Reset while the read waits for bank data: no response may follow.
    s_axi_araddr = 32'h08; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (s_axi_arready) break;
      @(posedge clk); #1;
    end
    chk("rw_ar_accepted", s_axi_arready, 1'b1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    @(negedge clk);
    chk("rw_read_en", read_en, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rw_arready_in_reset", s_axi_arready, 1'b0);
    chk("rw_awready_in_reset", s_axi_awready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rw_arready_after_reset", s_axi_arready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("rw_no_rvalid", s_axi_rvalid, 1'b0);
      @(posedge clk); #1; @(negedge clk);
    end
    s_axi_rready = 1'b0;
    @(posedge clk); #1;

    // Random traffic against the model.
    for (int i = 0; i < 40; i++) begin
      a = pool[$urandom_range(0, 6)];
      rs = model_err(a) ? SLV : OK;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), rs);
        if (!model_err(a)) ref_write(a, d, s);
      end else begin
        e = model_err(a) ? 32'h0 : ref_mem[(a / 4) % 64];
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 2), e, rs);
      end
    end

    // Idle bus: no stray strobes.
    we_snap = we_cnt; re_snap = re_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_write_en", we_cnt - we_snap, 0);
    chk("idle_read_en", re_cnt - re_snap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
